// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
//   sb_entry_t      : one buffered store, {addr, data}
//   SbDepthDefault  : default number of buffered stores
//   SbWordCmpW      : address bits compared for forwarding (word granularity)
//   SbCountW        : width of the occupancy count
//   word_match()    : true when two byte addresses fall in the same 32-bit word
package sb_pkg;

  localparam int unsigned SbDepthDefault = 4;
  localparam int unsigned SbWordCmpW     = 30;
  localparam int unsigned SbCountW       = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:32-SbWordCmpW] == b[31:32-SbWordCmpW];
  endfunction

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the store buffer FIFO.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_push, i_pop   : enqueue at tail / dequeue at head this cycle
//   o_head, o_tail  : current head (oldest) and tail (next free) slots
//   o_count         : number of valid entries
//   o_full, o_empty : occupancy flags
// Requests that would overflow or underflow are ignored.
module sb_fifo_ctrl
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepthDefault,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic                i_pop,
  output logic [PtrW-1:0]     o_head,
  output logic [PtrW-1:0]     o_tail,
  output logic [SbCountW-1:0] o_count,
  output logic                o_full,
  output logic                o_empty
);

  logic [PtrW-1:0]     r_head;
  logic [PtrW-1:0]     r_tail;
  logic [SbCountW-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == SbCountW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + SbCountW'(1);
        2'b01:   r_count <= r_count - SbCountW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

endmodule

// File: rtl/store_buffer.sv
// Store buffer sitting between the single-cycle core and the data syncram.
// Stores are queued and written back to memory in program order whenever the
// memory port is not needed by a load; loads see the youngest matching store.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   cpu_addr, cpu_wdata   : CPU byte address / store data
//   cpu_wr, cpu_rd        : CPU store / load request this cycle
//   cpu_rdata             : load data (forwarded or from memory)
//   stall                 : store arrived while the buffer is full
//   mem_addr, mem_din     : syncram address / write data
//   mem_we                : syncram write enable (one drain per cycle)
//   mem_dout              : syncram read data
//   empty, count          : occupancy status
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepthDefault,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  output logic [31:0]         cpu_rdata,
  output logic                stall,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_din,
  output logic                mem_we,
  input  logic [31:0]         mem_dout,
  output logic                empty,
  output logic [SbCountW-1:0] count
);

  sb_entry_t           r_entries [DEPTH];
  logic [DEPTH-1:0]    r_valid;
  logic [PtrW-1:0]     w_head;
  logic [PtrW-1:0]     w_tail;
  logic [SbCountW-1:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_hit;
  logic [31:0]         w_fwd_data;
  logic [PtrW-1:0]     w_scan_idx;

  // A full buffer refuses the store even if a drain frees a slot this cycle.
  assign w_push = cpu_wr & ~w_full;
  // Loads own the memory port; draining waits for a load-free cycle.
  assign w_pop  = ~w_empty & ~cpu_rd;

  sb_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Entry storage needs no reset: r_valid gates every use.
  always_ff @(posedge clk) begin
    if (w_push) r_entries[w_tail] <= '{addr: cpu_addr, data: cpu_wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_pop)  r_valid[w_head] <= 1'b0;
      if (w_push) r_valid[w_tail] <= 1'b1;
    end
  end

  // Walk from oldest to youngest; the last match wins, i.e. the youngest store.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_scan_idx = w_head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_scan_idx = w_head + PtrW'(k);
      if (r_valid[w_scan_idx] && word_match(r_entries[w_scan_idx].addr, cpu_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_entries[w_scan_idx].data;
      end
    end
  end

  assign cpu_rdata = w_hit ? w_fwd_data : mem_dout;

  always_comb begin
    mem_we   = w_pop;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_rd) begin
      mem_addr = cpu_addr;
    end else if (w_pop) begin
      mem_addr = r_entries[w_head].addr;
      mem_din  = r_entries[w_head].data;
    end
  end

  assign stall = cpu_wr & w_full;
  assign empty = w_empty;
  assign count = w_count;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: the driver predicts each cycle's outputs
// from a queue-based model and pushes them; a monitor pops and compares.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout = '0;
  logic        empty;
  logic [4:0]  count;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .empty     (empty),
    .count     (count)
  );

  typedef struct {
    logic        stall;
    logic [4:0]  count;
    logic        empty;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  cyc_exp_t exp_q[$];
  st_t      wr_q[$];     // memory writes still owed, in order
  st_t      model_q[$];  // buffered stores, oldest first
  int       m_head = 0;
  int       m_tail = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  cyc_exp_t mon_e;
  st_t      mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One CPU cycle: drive inputs, predict outputs, advance the model.
  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
    cyc_exp_t e;
    bit full;
    bit drain;
    @(negedge clk);
    cpu_wr    = wr;
    cpu_rd    = rd;
    cpu_addr  = addr;
    cpu_wdata = data;
    mem_dout  = $urandom;
    full  = (model_q.size() == DEPTH);
    drain = (model_q.size() != 0) && !rd;
    e.stall = wr && full;
    e.count = 5'(model_q.size());
    e.empty = (model_q.size() == 0);
    e.we    = drain;
    e.addr  = rd ? addr : (drain ? model_q[0].addr : 32'h0);
    e.din   = drain ? model_q[0].data : 32'h0;
    e.rdata = mem_dout;
    foreach (model_q[i]) begin
      if (model_q[i].addr[31:2] == addr[31:2]) e.rdata = model_q[i].data;
    end
    exp_q.push_back(e);
    if (drain) begin
      wr_q.push_back(model_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (wr && !full) begin
      model_q.push_back('{addr, data});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic flush();
    int guard = 0;
    while (model_q.size() != 0 && guard < 4 * DEPTH) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      guard++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    #1 reset = 1'b1;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_empty", 32'(empty), 32'd1);
    check("midreset_mem_we", 32'(mem_we), 32'd0);
    model_q.delete();
    wr_q.delete();
    m_head = 0;
    m_tail = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare each predicted cycle and every memory write.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("stall", 32'(stall), 32'(mon_e.stall));
      check("count", 32'(count), 32'(mon_e.count));
      check("empty", 32'(empty), 32'(mon_e.empty));
      check("mem_we", 32'(mem_we), 32'(mon_e.we));
      check("mem_addr", mem_addr, mon_e.addr);
      check("mem_din", mem_din, mon_e.din);
      check("cpu_rdata", cpu_rdata, mon_e.rdata);
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got mem_we=1 addr 0x%08h, required no write", mem_addr);
      end else begin
        mon_w = wr_q.pop_front();
        check("write_order_addr", mem_addr, mon_w.addr);
        check("write_order_data", mem_din, mon_w.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic drain
    drive(1'b1, 1'b0, 32'h40, 32'h1111_1111);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Forwarding of the youngest store, sub-word load address
    drive(1'b1, 1'b1, 32'h80, 32'hAAAA_0000);
    drive(1'b1, 1'b1, 32'h80, 32'hAAAA_0001);
    drive(1'b0, 1'b1, 32'h83, 32'h0);
    flush();

    // Full / stall with loads blocking the drain
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    drive(1'b1, 1'b1, 32'h210, 32'hC0DE_0004);
    drive(1'b1, 1'b1, 32'h210, 32'hC0DE_0004);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h210, 32'hC0DE_0004);
    flush();

    // Load miss on empty buffer
    drive(1'b0, 1'b1, 32'h100, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset mid-operation discards queued stores
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
    async_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Simultaneous enqueue and drain with tail wrap 3 -> 0
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'hBEEF_0000 + 32'(i));
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h40C, 32'hBEEF_0003);
    @(posedge clk);
    #1;
    check("wrap_tail", 32'(dut.u_ctrl.r_tail), 32'(m_tail));
    check("wrap_head", 32'(dut.u_ctrl.r_head), 32'(m_head));
    check("wrap_count", 32'(count), 32'(model_q.size()));
    flush();

    // Randomized traffic over a small address window to exercise hits
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            32'h40 + 32'($urandom_range(0, 31)), $urandom);
    end
    flush();

    @(negedge clk);
    #3;
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("cycles_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
